t08_touch_event_fifo: RTL
=========================

Name: t08_touch_event_fifo

Overview:
- Buffers touchscreen coordinate words between the I2C/interrupt controller and the MMIO block.
- Without it, a touch sample arriving while the CPU is busy overwrites the previous one. This block queues samples instead.
- Upstream side: takes the I2C 32-bit data word and its one-cycle done strobe.
- Downstream side: the MMIO pops entries through a show-ahead read port and polls status (count, full, overflow, dropped-sample counter).

Parameters:
- DEPTH, 8, number of 32-bit entries; must be a power of two, range 2..64.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- push_i  in  1  I2C done strobe; one sample per asserted cycle.
- push_data_i  in  32  I2C coordinate word.
- dedup_en_i  in  1  when 1, suppress pushes identical to the last accepted word.
- pop_i  in  1  MMIO consumes the head entry.
- pop_data_o  out  32  head entry (show-ahead); 0 when empty.
- valid_o  out  1  FIFO non-empty.
- full_o  out  1  count == DEPTH.
- count_o  out  CNT_W  current occupancy.
- overflow_o  out  1  sticky; set when a push is dropped because the FIFO is full.
- drop_count_o  out  DROP_W  dropped pushes, saturating at all-ones.
- ovf_clear_i  in  1  clears overflow_o and drop_count_o.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr, count, overflow, drop_count and the last-word-valid flag go to 0.
  - Outputs: valid_o=0, full_o=0, count_o=0, overflow_o=0, drop_count_o=0, pop_data_o=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued entries immediately; no partial state survives.
- Storage: DEPTH x 32 register array. wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Show-ahead read:
  - pop_data_o = mem[rd_ptr] when count != 0, else 32'h0.
  - The data is valid in the same cycle valid_o rises, which is one cycle after the accepting push edge.
- Pop: pop_i && valid_o advances rd_ptr and decrements count at the edge. pop_i while empty is ignored with no side effects.
- Push acceptance (push_i=1), evaluated in order:
  1. Dedup: if dedup_en_i=1, the last-word-valid flag is 1, and push_data_i == last_word, the push is suppressed. No write, no drop count, overflow untouched.
  2. Full: if count == DEPTH and no simultaneous pop is accepted, the push is dropped. overflow_o is set; drop_count_o increments unless already all-ones.
  3. Otherwise the word is written at mem[wr_ptr], wr_ptr advances, last_word is loaded with the word, and last-word-valid is set to 1.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - Full: the pop frees a slot and the push is accepted; count stays DEPTH; no overflow.
  - Empty: the pop is ignored and the push is accepted; count becomes 1.
- Count arithmetic: count_next = count + accepted_push - accepted_pop. It never exceeds DEPTH and never underflows.
- Clearing: ovf_clear_i=1 zeroes overflow_o and drop_count_o at the edge. If a drop occurs in the same cycle, set wins: overflow_o=1 and drop_count_o=1.
- last_word is not cleared by pops. Dedup therefore also applies when the FIFO has drained, until reset.
- Timing: all outputs are registered or decoded directly from registers. No combinational path exists from push_i or pop_i to any output.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> valid_o=0, count_o=0, full_o=0, overflow_o=0, drop_count_o=0, pop_data_o=32'h0.
- Basic ordering, DEPTH=8, dedup_en_i=0:
  - Push 32'h0010_0020, 32'h0030_0040, 32'h0050_0060 on consecutive cycles -> count_o=3.
  - pop_data_o=32'h0010_0020 before any pop.
  - Three pops return the words in push order; count_o=0 and pop_data_o=0 afterwards.
- Overflow and saturation, DEPTH=8:
  - Push 8 distinct words -> full_o=1.
  - Push 3 more -> overflow_o=1, drop_count_o=3; the head word is still the first word pushed.
  - Push 260 more -> drop_count_o=8'hFF.
  - Assert ovf_clear_i with push_i=1 in the same cycle -> overflow_o=1, drop_count_o=1.
- Simultaneous push and pop:
  - When full: push 32'hAAAA_0001 with pop_i=1 -> count_o stays 8, no overflow; after 8 pops the last word popped is 32'hAAAA_0001.
  - When empty: push and pop in the same cycle -> count_o=1, pop_data_o equals the pushed word.
- Dedup, dedup_en_i=1:
  - Push 32'h1234_5678 twice, then 32'h1234_5679 -> count_o=2, drop_count_o=0.
  - Drain, then push 32'h1234_5679 again -> suppressed, count_o=0.
  - Set dedup_en_i=0 and repeat the push -> accepted, count_o=1.
- Wrap-around and reset mid-operation:
  - Run 20 push/pop cycles at DEPTH=4 -> data order preserved across pointer wrap.
  - Assert rst with count_o=3 -> next cycle count_o=0, valid_o=0.
  - A subsequent identical word with dedup_en_i=1 is accepted, because reset clears the last-word-valid flag.

Source files
------------

// File: rtl/t08_touch_event_fifo.sv
// t08_touch_event_fifo: queues touch coordinate samples between the I2C controller and MMIO.
// Show-ahead read port, sticky overflow, saturating drop counter, optional duplicate suppression.
module t08_touch_event_fifo #(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [31:0]       push_data_i,
    input  logic              dedup_en_i,
    input  logic              pop_i,
    output logic [31:0]       pop_data_o,
    output logic              valid_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_count_o,
    input  logic              ovf_clear_i
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, last_vld_q, last_vld_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [31:0]       last_q, last_d;
    logic              full, do_pop, dup, do_drop, do_push;

    assign full    = count_q == CNT_W'(DEPTH);
    assign do_pop  = pop_i && count_q != '0;
    assign dup     = dedup_en_i && last_vld_q && push_data_i == last_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_drop = push_i && !dup && full && !do_pop;
    assign do_push = push_i && !dup && !do_drop;

    always_comb begin
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        last_d     = do_push ? push_data_i : last_q;
        last_vld_d = last_vld_q || do_push;
        ovf_d      = do_drop ? 1'b1 : (ovf_clear_i ? 1'b0 : ovf_q);
        drop_d     = do_drop ? (ovf_clear_i ? DROP_W'(1) : (&drop_q ? drop_q : drop_q + DROP_W'(1)))
                             : (ovf_clear_i ? '0 : drop_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o   = count_q != '0 ? mem_q[rd_ptr_q] : 32'h0;
    assign valid_o      = count_q != '0;
    assign full_o       = full;
    assign count_o      = count_q;
    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;
endmodule
